canvas_clear_arbiter: RTL

Shares the single write path into the drawing canvases between the freehand tool and a built-in layer-clear sequencer. Sits between `freehand_tool` and the `drawing_canvas` instances. It drives one registered write bus plus a one-hot per-layer write enable. A clear request sweeps every pixel of one layer to `COLOR_NONE`, interleaving with live tool traffic.

---
 rtl/canvas_clear_arbiter_if.sv | 37 +++
 rtl/canvas_clear_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/canvas_clear_arbiter_if.sv
// canvas_clear_arbiter_if: tool pixel handshake, clear request/status and
// the shared canvas write bus. The arbiter connects through the slave
// modport; whoever drives the tool and clear request uses the master modport.
interface canvas_clear_arbiter_if #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int LAYERS      = 4,
    parameter int COLOR_WIDTH = 8
);
    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(HEIGHT);

    logic                   clear_req;
    logic [2:0]             clear_layer;
    logic                   tool_valid;
    logic                   tool_ready;
    logic [2:0]             tool_layer;
    logic [X_W-1:0]         tool_x;
    logic [Y_W-1:0]         tool_y;
    logic [COLOR_WIDTH-1:0] tool_color;
    logic [LAYERS-1:0]      wr_en;
    logic [X_W-1:0]         wr_x;
    logic [Y_W-1:0]         wr_y;
    logic [COLOR_WIDTH-1:0] wr_color;
    logic                   busy;
    logic                   clear_done;

    modport master (
        output clear_req, clear_layer, tool_valid, tool_layer, tool_x, tool_y, tool_color,
        input  tool_ready, wr_en, wr_x, wr_y, wr_color, busy, clear_done
    );

    modport slave (
        input  clear_req, clear_layer, tool_valid, tool_layer, tool_x, tool_y, tool_color,
        output tool_ready, wr_en, wr_x, wr_y, wr_color, busy, clear_done
    );
endinterface

// File: rtl/canvas_clear_arbiter.sv
// canvas_clear_arbiter: shares the single canvas write path between the
// freehand tool and a layer-clear sweep. The tool wins any slot it asks for;
// otherwise a running clear writes the next pixel in row-major order.
// Optional feature: define CLEAR_FAIRNESS_EN to cap consecutive tool grants
// at MAX_TOOL_BURST while a clear is running; without it the tool has strict
// priority and can starve the sweep.
module canvas_clear_arbiter #(
    parameter int                     WIDTH          = 640,
    parameter int                     HEIGHT         = 480,
    parameter int                     LAYERS         = 4,
    parameter int                     MAX_TOOL_BURST = 8,
    parameter int                     COLOR_WIDTH    = 8,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE     = {COLOR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    canvas_clear_arbiter_if.slave bus
);
    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(HEIGHT);
    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t                 state_r, state_nxt_s;
    logic [2:0]             layer_r;
    logic [X_W-1:0]         cx_r;
    logic [Y_W-1:0]         cy_r;
    logic                   tool_ready_s, tool_grant_s, clear_grant_s, last_pix_s;
    logic                   fair_block_s;
    logic [LAYERS-1:0]      wr_en_r;
    logic [X_W-1:0]         wr_x_r;
    logic [Y_W-1:0]         wr_y_r;
    logic [COLOR_WIDTH-1:0] wr_color_r;
    logic                   busy_r, clear_done_r;

    // Layer numbers are 1-based; 0 and anything above LAYERS are illegal.
    function automatic logic layer_legal(input logic [2:0] layer);
        return (layer != 3'd0) && (32'(layer) <= 32'(LAYERS));
    endfunction

    // One-hot enable for a 1-based layer; illegal layers give all zeros.
    function automatic logic [LAYERS-1:0] layer_onehot(input logic [2:0] layer);
        logic [LAYERS-1:0] oh;
        oh = {LAYERS{1'b0}};
        for (int k = 0; k < LAYERS; k++) begin
            if (32'(layer) == 32'(k + 1)) begin
                oh[k] = 1'b1;
            end else begin
                oh[k] = 1'b0;
            end
        end
        return oh;
    endfunction

`ifdef CLEAR_FAIRNESS_EN
    localparam int BURST_W = $clog2(MAX_TOOL_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_TOOL_BURST);

    logic [BURST_W-1:0] burst_r;

    // Count back-to-back tool grants during a clear; any sweep slot resets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_r <= {BURST_W{1'b0}};
        end else if ((state_r != ST_CLEAR) || clear_grant_s) begin
            burst_r <= {BURST_W{1'b0}};
        end else if (tool_grant_s) begin
            burst_r <= burst_r + BURST_W'(1);
        end else begin
            burst_r <= burst_r;
        end
    end

    assign fair_block_s = (state_r == ST_CLEAR) && (burst_r >= BURST_MAX);
`else
    assign fair_block_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: start on a legal request, finish on the slot for the last pixel.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.clear_req && layer_legal(bus.clear_layer)) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clear_grant_s && last_pix_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Slot arbitration: tool first, then the sweep while clearing.
    always_comb begin
        tool_ready_s  = !fair_block_s;
        tool_grant_s  = bus.tool_valid && tool_ready_s;
        last_pix_s    = (cx_r == X_LAST) && (cy_r == Y_LAST);
        if (state_r == ST_CLEAR) begin
            clear_grant_s = !tool_grant_s;
        end else begin
            clear_grant_s = 1'b0;
        end
    end

    // Sweep position and latched layer; counters sit at zero while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            layer_r <= 3'd0;
            cx_r    <= {X_W{1'b0}};
            cy_r    <= {Y_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            cx_r <= {X_W{1'b0}};
            cy_r <= {Y_W{1'b0}};
            if (state_nxt_s == ST_CLEAR) begin
                layer_r <= bus.clear_layer;
            end else begin
                layer_r <= layer_r;
            end
        end else if (clear_grant_s) begin
            if (cx_r == X_LAST) begin
                cx_r <= {X_W{1'b0}};
                cy_r <= (cy_r == Y_LAST) ? {Y_W{1'b0}} : cy_r + Y_W'(1);
            end else begin
                cx_r <= cx_r + X_W'(1);
                cy_r <= cy_r;
            end
        end else begin
            cx_r <= cx_r;
            cy_r <= cy_r;
        end
    end

    // Registered write bus and status; coordinates/colour hold on empty slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_r      <= {LAYERS{1'b0}};
            wr_x_r       <= {X_W{1'b0}};
            wr_y_r       <= {Y_W{1'b0}};
            wr_color_r   <= COLOR_NONE;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b0;
        end else begin
            if (tool_grant_s) begin
                wr_en_r    <= layer_onehot(bus.tool_layer);
                wr_x_r     <= bus.tool_x;
                wr_y_r     <= bus.tool_y;
                wr_color_r <= bus.tool_color;
            end else if (clear_grant_s) begin
                wr_en_r    <= layer_onehot(layer_r);
                wr_x_r     <= cx_r;
                wr_y_r     <= cy_r;
                wr_color_r <= COLOR_NONE;
            end else begin
                wr_en_r    <= {LAYERS{1'b0}};
                wr_x_r     <= wr_x_r;
                wr_y_r     <= wr_y_r;
                wr_color_r <= wr_color_r;
            end
            busy_r       <= (state_nxt_s == ST_CLEAR);
            clear_done_r <= clear_grant_s && last_pix_s;
        end
    end

    assign bus.tool_ready = tool_ready_s;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_x       = wr_x_r;
    assign bus.wr_y       = wr_y_r;
    assign bus.wr_color   = wr_color_r;
    assign bus.busy       = busy_r;
    assign bus.clear_done = clear_done_r;
endmodule
